turbo_llr_frame_assembler: RTL

Upstream stage of `turbo_decode`. It accepts received soft values as a stream, one triplet per cycle (systematic, parity-1, parity-2), and assembles them into ping-pong frame banks. It then presents one complete frame as the `y[3][N+TAIL_BITS]` array, together with a single-cycle `out_valid` pulse that drives the decoder's `in_valid`. Because `turbo_decode` has no back-pressure, the block enforces a minimum spacing of `FRAME_GAP` cycles between frame pulses.

---
 rtl/turbo_llr_pkg.sv | 21 ++
 rtl/turbo_llr_frame_assembler_bank.sv | 33 +++
 rtl/turbo_llr_frame_assembler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/turbo_llr_pkg.sv
// Shared constants, soft-value/frame types and output FSM states for the turbo LLR frame assembler.
package turbo_llr_pkg;

   localparam int BITS      = 32;
   localparam int N         = 64;
   localparam int NOUT      = 2;
   localparam int TAIL_BITS = 2;
   localparam int STREAMS   = 1 + 2 * (NOUT - 1);
   localparam int SYMBOLS   = N + TAIL_BITS;
   localparam int IDX_W     = $clog2(SYMBOLS);

   typedef logic [BITS-1:0] soft_t;
   typedef soft_t [STREAMS-1:0] triplet_t;
   typedef soft_t [STREAMS-1:0][SYMBOLS-1:0] frame_t;

   typedef enum logic {
      IDLE,
      GAP
   } out_state_t;

endpackage

// File: rtl/turbo_llr_frame_assembler_bank.sv
// One ping-pong frame bank: single triplet write port, tail erasure strobe and full-array read.
module llr_frame_bank
   import turbo_llr_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  triplet_t         wdata,
   input  logic             tail_zero,
   output frame_t           data
);

   frame_t mem;

   // Storage is deliberately not reset: the top masks y outside the frame pulse.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int s = 0; s < STREAMS; s++) begin
            mem[s][idx] <= wdata[s];
         end
      end
      if (tail_zero) begin
         for (int s = 0; s < STREAMS; s++) begin
            for (int i = N; i < SYMBOLS; i++) begin
               mem[s][i] <= '0;
            end
         end
      end
   end

   assign data = mem;

endmodule

// File: rtl/turbo_llr_frame_assembler.sv
// Assembles streamed soft-value triplets into ping-pong banks and releases paced frames to turbo_decode.
// Optional TURBO_TAIL_ZERO_FILL_EN: stream only the N information symbols and write the tail as erasures.
module turbo_llr_frame_assembler
   import turbo_llr_pkg::*;
#(
   parameter int FRAME_GAP = N * 5
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     in_valid,
   output logic     in_ready,
   input  triplet_t in_y,
   output logic     out_valid,
   output frame_t   y
);

`ifdef TURBO_TAIL_ZERO_FILL_EN
   localparam int FRAME_LEN = N;
   localparam bit TAIL_ZERO = 1'b1;
`else
   localparam int FRAME_LEN = SYMBOLS;
   localparam bit TAIL_ZERO = 1'b0;
`endif
   localparam int               GAP_W    = $clog2(FRAME_GAP + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(FRAME_GAP - 1);

   logic             fill_bank;
   logic             out_bank;
   logic             pulse_bank;
   logic [IDX_W-1:0] fill_idx;
   logic [1:0]       full;
   logic [GAP_W-1:0] gap_cnt;
   logic [GAP_W-1:0] gap_cnt_next;
   out_state_t       state;
   out_state_t       state_next;
   logic             handshake;
   logic             fill_done;
   logic             release_bank;
   logic [1:0]       bank_we;
   logic [1:0]       bank_tail;
   frame_t           bank_data [2];

   assign in_ready  = !full[fill_bank];
   assign handshake = in_valid && in_ready;
   assign fill_done = handshake && (fill_idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_idx  <= '0;
         fill_bank <= 1'b0;
      end else if (fill_done) begin
         fill_idx  <= '0;
         fill_bank <= !fill_bank;
      end else if (handshake) begin
         fill_idx <= fill_idx + 1'b1;
      end
   end

   // The bank being filled is never the full one being released, so set and clear never collide.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (fill_done && (fill_bank == 1'(b))) begin
               full[b] <= 1'b1;
            end else if (release_bank && (out_bank == 1'(b))) begin
               full[b] <= 1'b0;
            end
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign bank_we[b]   = handshake && (fill_bank == 1'(b));
      assign bank_tail[b] = TAIL_ZERO && fill_done && (fill_bank == 1'(b));

      llr_frame_bank u_bank (
         .clk       (clk),
         .we        (bank_we[b]),
         .idx       (fill_idx),
         .wdata     (in_y),
         .tail_zero (bank_tail[b]),
         .data      (bank_data[b])
      );
   end

   // out_valid is registered, so the pulse lands the cycle after the release decision.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         gap_cnt    <= '0;
         out_bank   <= 1'b0;
         pulse_bank <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         state     <= state_next;
         gap_cnt   <= gap_cnt_next;
         out_valid <= release_bank;
         if (release_bank) begin
            out_bank   <= !out_bank;
            pulse_bank <= out_bank;
         end
      end
   end

   always_comb begin
      state_next   = state;
      gap_cnt_next = gap_cnt;
      case (state)
         IDLE: begin
            if (full[out_bank]) begin
               gap_cnt_next = GAP_LOAD;
               state_next   = (FRAME_GAP == 1) ? IDLE : GAP;
            end
         end
         GAP: begin
            gap_cnt_next = gap_cnt - 1'b1;
            if (gap_cnt <= GAP_W'(1)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      release_bank = 1'b0;
      if ((state == IDLE) && full[out_bank]) begin
         release_bank = 1'b1;
      end
   end

   assign y = out_valid ? bank_data[pulse_bank] : '0;

endmodule
